// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int WB_XLEN         = 32;
    localparam int WB_FIFO_DEPTH   = 2;
    localparam int WB_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular queue of LLU results; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter.
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [4:0]           pushRd,
    input  logic [WB_XLEN-1:0]   pushData,
    input  logic                 pop,
    output logic [4:0]           headRd,
    output logic [WB_XLEN-1:0]   headData,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH-1:0]     entryValid,
    output logic [DEPTH*5-1:0]   entryRd
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW:0]     wrPtrReg;
    logic [AW:0]     rdPtrReg;
    logic [AW:0]     count;

    assign count = wrPtrReg - rdPtrReg;
    assign empty = (wrPtrReg == rdPtrReg);
    assign full  = (wrPtrReg[AW] != rdPtrReg[AW]) &&
                   (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (push && !full) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (pop && !empty) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
        end
    end

    // Payload storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtrReg[AW-1:0]] <= '{rd: pushRd, data: pushData};
        end
    end

    assign headRd   = mem[rdPtrReg[AW-1:0]].rd;
    assign headData = mem[rdPtrReg[AW-1:0]].data;

    // A slot is occupied when its distance from the read pointer is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
            logic [AW-1:0] offset;
            assign offset           = AW'(gi) - rdPtrReg[AW-1:0];
            assign entryValid[gi]   = ({1'b0, offset} < count);
            assign entryRd[gi*5 +: 5] = mem[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between the pipeline WB stage and queued LLU results.
// Optional same-cycle LLU bypass into an idle write port: define WB_BYPASS_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
    parameter int XLEN         = WB_XLEN   // must equal WB_XLEN (queue entry width)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_wb_en,
    input  logic [4:0]      pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    output logic            pipe_wb_accept,
    input  logic            llu_valid,
    output logic            llu_ready,
    input  logic [4:0]      llu_rd,
    input  logic [XLEN-1:0] llu_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall_req,
    output logic [31:0]     pending_mask
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic              full;
    logic              empty;
    logic [4:0]        headRd;
    logic [XLEN-1:0]   headData;
    logic [DEPTH-1:0]  entryValid;
    logic [DEPTH*5-1:0] entryRd;

    logic              bypass;
    logic              push;
    logic              grantFifo;
    logic              grantPipe;
    logic              stallReg;
    logic              stallNext;
    logic [CW-1:0]     starveCntReg;
    logic [CW-1:0]     starveCntNext;
    logic [31:0]       pendingNext;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pushRd     (llu_rd),
        .pushData   (llu_data),
        .pop        (grantFifo),
        .headRd     (headRd),
        .headData   (headData),
        .full       (full),
        .empty      (empty),
        .entryValid (entryValid),
        .entryRd    (entryRd)
    );

    assign llu_ready = !full;

`ifdef WB_BYPASS_EN
    assign bypass = empty && !pipe_wb_en && !stallReg && llu_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result goes straight to the RF and never occupies a slot.
    assign push = llu_valid && llu_ready && !bypass;

    always_comb begin
        grantFifo = 1'b0;
        grantPipe = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        if (stallReg && !empty) begin
            grantFifo = 1'b1;
        end else if (pipe_wb_en) begin
            grantPipe = 1'b1;
        end else if (!empty) begin
            grantFifo = 1'b1;
        end
        if (grantFifo) begin
            rf_we    = (headRd != 5'd0);
            rf_waddr = headRd;
            rf_wdata = headData;
        end else if (grantPipe) begin
            rf_we    = (pipe_wb_rd != 5'd0);
            rf_waddr = pipe_wb_rd;
            rf_wdata = pipe_wb_data;
        end else if (bypass) begin
            rf_we    = (llu_rd != 5'd0);
            rf_waddr = llu_rd;
            rf_wdata = llu_data;
        end
    end

    assign pipe_wb_accept = grantPipe;

    // Count cycles the queue loses to the pipeline; reaching the limit forces one drain.
    always_comb begin
        starveCntNext = starveCntReg;
        if (grantFifo || empty) begin
            starveCntNext = '0;
        end else if (pipe_wb_en && !stallReg && starveCntReg != CW'(STARVE_LIMIT)) begin
            starveCntNext = starveCntReg + 1'b1;
        end
        stallNext = (starveCntNext == CW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starveCntReg <= '0;
            stallReg     <= 1'b0;
        end else begin
            starveCntReg <= starveCntNext;
            stallReg     <= stallNext;
        end
    end

    assign stall_req = stallReg;

    always_comb begin
        pendingNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) begin
                pendingNext[entryRd[i*5 +: 5]] = 1'b1;
            end
        end
        pendingNext[0] = 1'b0;
    end

    assign pending_mask = pendingNext;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; expected values are hand-derived per step.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_wb_accept;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [31:0] pending_mask;

    int vectors = 0;
    int miscompares = 0;

    wb_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_wb_en     (pipe_wb_en),
        .pipe_wb_rd     (pipe_wb_rd),
        .pipe_wb_data   (pipe_wb_data),
        .pipe_wb_accept (pipe_wb_accept),
        .llu_valid      (llu_valid),
        .llu_ready      (llu_ready),
        .llu_rd         (llu_rd),
        .llu_data       (llu_data),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .stall_req      (stall_req),
        .pending_mask   (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=0x%0h expected=0x%0h", vectors, tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        pipe_wb_en = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
        llu_valid = 1'b0; llu_rd = '0; llu_data = '0;

        // Reset state
        cyc(); cyc(); settle();
        check("rst_llu_ready", 32'(llu_ready), 32'd1);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_accept", 32'(pipe_wb_accept), 32'd0);
        rst = 1'b0;
        cyc();

`ifndef WB_BYPASS_EN
        // Idle pipeline: LLU result lands one cycle later
        llu_valid = 1'b1; llu_rd = 5'd5; llu_data = 32'hAAAA_0001;
        settle();
        check("t1_c0_ready", 32'(llu_ready), 32'd1);
        check("t1_c0_we", 32'(rf_we), 32'd0);
        cyc();
        llu_valid = 1'b0;
        settle();
        check("t1_c1_we", 32'(rf_we), 32'd1);
        check("t1_c1_waddr", 32'(rf_waddr), 32'd5);
        check("t1_c1_wdata", rf_wdata, 32'hAAAA_0001);
        check("t1_c1_pending", pending_mask, 32'h0000_0020);
        cyc(); settle();
        check("t1_c2_we", 32'(rf_we), 32'd0);
        check("t1_c2_pending", pending_mask, 32'd0);
        cyc();
`else
        // Idle pipeline with bypass: same-cycle write, nothing queued
        llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h0000_0999;
        settle();
        check("byp_c0_we", 32'(rf_we), 32'd1);
        check("byp_c0_waddr", 32'(rf_waddr), 32'd9);
        check("byp_c0_wdata", rf_wdata, 32'h0000_0999);
        check("byp_c0_pending", pending_mask, 32'd0);
        cyc();
        llu_valid = 1'b0;
        settle();
        check("byp_c1_we", 32'(rf_we), 32'd0);
        check("byp_c1_pending", pending_mask, 32'd0);
        cyc();
`endif

        // Busy pipeline starves the queue until the forced stall
        pipe_wb_en = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h0000_1111;
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h0000_0077;
        settle();
        check("t2_c0_accept", 32'(pipe_wb_accept), 32'd1);
        check("t2_c0_waddr", 32'(rf_waddr), 32'd3);
        cyc();
        llu_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            check($sformatf("t2_c%0d_accept", c), 32'(pipe_wb_accept), 32'd1);
            check($sformatf("t2_c%0d_stall", c), 32'(stall_req), 32'd0);
            check($sformatf("t2_c%0d_pending", c), pending_mask, 32'h0000_0080);
            cyc();
        end
        settle();
        check("t2_c5_stall", 32'(stall_req), 32'd1);
        check("t2_c5_accept", 32'(pipe_wb_accept), 32'd0);
        check("t2_c5_we", 32'(rf_we), 32'd1);
        check("t2_c5_waddr", 32'(rf_waddr), 32'd7);
        check("t2_c5_wdata", rf_wdata, 32'h0000_0077);
        cyc(); settle();
        check("t2_c6_stall", 32'(stall_req), 32'd0);
        check("t2_c6_accept", 32'(pipe_wb_accept), 32'd1);
        check("t2_c6_waddr", 32'(rf_waddr), 32'd3);
        check("t2_c6_pending", pending_mask, 32'd0);
        pipe_wb_en = 1'b0;
        cyc();

        // Three back-to-back pushes against a busy pipeline: backpressure and order
        pipe_wb_en = 1'b1; pipe_wb_rd = 5'd4; pipe_wb_data = 32'h0000_0044;
        llu_valid = 1'b1; llu_rd = 5'd10; llu_data = 32'h0000_000A;
        settle();
        check("t3_c0_ready", 32'(llu_ready), 32'd1);
        cyc();
        llu_rd = 5'd11; llu_data = 32'h0000_000B;
        settle();
        check("t3_c1_ready", 32'(llu_ready), 32'd1);
        cyc();
        llu_rd = 5'd12; llu_data = 32'h0000_000C;
        settle();
        check("t3_c2_ready", 32'(llu_ready), 32'd0);
        check("t3_c2_pending", pending_mask, 32'h0000_0C00);
        cyc(); settle();
        check("t3_c3_ready", 32'(llu_ready), 32'd0);
        cyc(); settle();
        check("t3_c4_ready", 32'(llu_ready), 32'd0);
        cyc(); settle();
        check("t3_c5_stall", 32'(stall_req), 32'd1);
        check("t3_c5_ready", 32'(llu_ready), 32'd0);
        check("t3_c5_accept", 32'(pipe_wb_accept), 32'd0);
        check("t3_c5_waddr", 32'(rf_waddr), 32'd10);
        check("t3_c5_wdata", rf_wdata, 32'h0000_000A);
        cyc(); settle();
        check("t3_c6_ready", 32'(llu_ready), 32'd1);
        check("t3_c6_accept", 32'(pipe_wb_accept), 32'd1);
        check("t3_c6_pending", pending_mask, 32'h0000_0800);
        cyc();
        llu_valid = 1'b0; pipe_wb_en = 1'b0;
        settle();
        check("t3_c7_waddr", 32'(rf_waddr), 32'd11);
        check("t3_c7_wdata", rf_wdata, 32'h0000_000B);
        check("t3_c7_pending", pending_mask, 32'h0000_1800);
        cyc(); settle();
        check("t3_c8_waddr", 32'(rf_waddr), 32'd12);
        check("t3_c8_wdata", rf_wdata, 32'h0000_000C);
        check("t3_c8_pending", pending_mask, 32'h0000_1000);
        cyc(); settle();
        check("t3_c9_we", 32'(rf_we), 32'd0);
        check("t3_c9_pending", pending_mask, 32'd0);
        cyc();

        // rd=0 result: granted and popped without an RF write
        pipe_wb_en = 1'b1; pipe_wb_rd = 5'd4; pipe_wb_data = 32'h0000_0044;
        llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'h0000_DEAD;
        settle();
        check("t4_c0_accept", 32'(pipe_wb_accept), 32'd1);
        cyc();
        pipe_wb_en = 1'b0;
        llu_rd = 5'd6; llu_data = 32'h0000_0066;
        settle();
        check("t4_c1_we", 32'(rf_we), 32'd0);
        check("t4_c1_pending", pending_mask, 32'd0);
        cyc();
        llu_valid = 1'b0;
        settle();
        check("t4_c2_we", 32'(rf_we), 32'd1);
        check("t4_c2_waddr", 32'(rf_waddr), 32'd6);
        check("t4_c2_wdata", rf_wdata, 32'h0000_0066);
        check("t4_c2_pending", pending_mask, 32'h0000_0040);
        cyc(); settle();
        check("t4_c3_we", 32'(rf_we), 32'd0);
        cyc();

        // Reset with two entries queued and a stall pending
        pipe_wb_en = 1'b1; pipe_wb_rd = 5'd4; pipe_wb_data = 32'h0000_0044;
        llu_valid = 1'b1; llu_rd = 5'd20; llu_data = 32'h0000_0020;
        cyc();
        llu_rd = 5'd21; llu_data = 32'h0000_0021;
        cyc();
        llu_valid = 1'b0;
        cyc(); cyc(); cyc(); settle();
        check("t5_pre_stall", 32'(stall_req), 32'd1);
        check("t5_pre_pending", pending_mask, 32'h0030_0000);
        rst = 1'b1;
        cyc();
        rst = 1'b0; pipe_wb_en = 1'b0;
        settle();
        check("t5_post_stall", 32'(stall_req), 32'd0);
        check("t5_post_pending", pending_mask, 32'd0);
        check("t5_post_ready", 32'(llu_ready), 32'd1);
        check("t5_post_we", 32'(rf_we), 32'd0);
        cyc(); settle();
        check("t5_post2_we", 32'(rf_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
